// File: rtl/johnson_phase_tracker.sv
// Johnson counter phase tracker: decodes the monitored counter state into a
// phase index, follows the expected phase-to-phase progression, declares lock
// after a run of correct steps and counts coding/sequencing errors.
module johnson_phase_tracker #(
    parameter int unsigned M        = 4,
    parameter int unsigned LOCK_CNT = 3,
    localparam int unsigned NP      = 2 * M,
    localparam int unsigned PW      = $clog2(2 * M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [M-1:0]  jc_in,
    input  logic          en,
    input  logic          clear_err,
    output logic [PW-1:0] phase_idx,
    output logic [NP-1:0] phase_onehot,
    output logic          phase_vld,
    output logic          locked,
    output logic          err_illegal,
    output logic          err_seq,
    output logic          wrap,
    output logic [7:0]    err_cnt
);

    localparam int unsigned SW      = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    state_e            state_q;
    logic [SW-1:0]     step_q;
    logic [PW-1:0]     phase_idx_q;
    logic [NP-1:0]     phase_onehot_q;
    logic              phase_vld_q;
    logic              err_illegal_q;
    logic              err_seq_q;
    logic              wrap_q;
    logic [CNT_W-1:0]  err_cnt_q;

    logic              dec_vld;
    logic [PW-1:0]     dec_idx;
    logic [PW-1:0]     next_idx;
    logic              is_next;
    logic              err_inc;

    // Legal code for phase p: ones filling from the LSB, then clearing from the LSB.
    function automatic logic [M-1:0] phase_code(input int unsigned p);
        logic [M-1:0] ones;
        ones = '1;
        if (p <= M) begin
            return ones >> (M - p);
        end
        return ones << (p - M);
    endfunction

    // Decode the sampled counter state against the full legal code table.
    always_comb begin
        dec_vld = 1'b0;
        dec_idx = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (jc_in == phase_code(p)) begin
                dec_vld = 1'b1;
                dec_idx = PW'(p);
            end
        end
    end

    // Expected successor of the last legal phase and error-increment request.
    always_comb begin
        next_idx = (phase_idx_q == PW'(NP - 1)) ? '0 : phase_idx_q + PW'(1);
        is_next  = (dec_idx == next_idx);
        err_inc  = en && (!dec_vld || ((state_q == ST_LOCKED) && !is_next));
    end

    // Lock FSM, step counter, registered phase outputs, pulses and error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_UNLOCKED;
            step_q         <= '0;
            phase_idx_q    <= '0;
            phase_onehot_q <= '0;
            phase_vld_q    <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_seq_q      <= 1'b0;
            wrap_q         <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            err_illegal_q <= 1'b0;
            err_seq_q     <= 1'b0;
            wrap_q        <= 1'b0;

            if (en) begin
                if (!dec_vld) begin
                    state_q        <= ST_UNLOCKED;
                    step_q         <= '0;
                    phase_vld_q    <= 1'b0;
                    phase_onehot_q <= '0;
                    err_illegal_q  <= 1'b1;
                end else begin
                    phase_idx_q    <= dec_idx;
                    phase_vld_q    <= 1'b1;
                    phase_onehot_q <= NP'(1) << dec_idx;
                    unique case (state_q)
                        ST_UNLOCKED: begin
                            state_q <= ST_ACQUIRE;
                            step_q  <= '0;
                        end
                        ST_ACQUIRE: begin
                            if (is_next) begin
                                if (step_q == SW'(LOCK_CNT - 1)) begin
                                    state_q <= ST_LOCKED;
                                    step_q  <= SW'(LOCK_CNT);
                                end else begin
                                    step_q <= step_q + SW'(1);
                                end
                            end else begin
                                step_q <= '0;
                            end
                        end
                        ST_LOCKED: begin
                            if (is_next) begin
                                wrap_q <= (phase_idx_q == PW'(NP - 1));
                            end else begin
                                state_q   <= ST_ACQUIRE;
                                step_q    <= '0;
                                err_seq_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_UNLOCKED;
                            step_q  <= '0;
                        end
                    endcase
                end
            end

            // Clear dominates any simultaneous increment; count saturates.
            if (clear_err) begin
                err_cnt_q <= '0;
            end else if (err_inc && (err_cnt_q != CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign phase_idx    = phase_idx_q;
    assign phase_onehot = phase_onehot_q;
    assign phase_vld    = phase_vld_q;
    assign locked       = (state_q == ST_LOCKED);
    assign err_illegal  = err_illegal_q;
    assign err_seq      = err_seq_q;
    assign wrap         = wrap_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Scoreboard bench for johnson_phase_tracker: directed scenarios followed by a
// randomized walk, each sample's expected outputs queued by a reference model.
module tb_johnson_phase_tracker;

    localparam int unsigned M  = 4;
    localparam int unsigned L  = 3;
    localparam int unsigned NP = 2 * M;
    localparam int unsigned PW = $clog2(2 * M);

    typedef struct packed {
        logic [PW-1:0] idx;
        logic [NP-1:0] oh;
        logic          vld;
        logic          lk;
        logic          eill;
        logic          eseq;
        logic          wrp;
        logic [7:0]    cnt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [M-1:0]  jc_in;
    logic          en;
    logic          clear_err;
    logic [PW-1:0] phase_idx;
    logic [NP-1:0] phase_onehot;
    logic          phase_vld;
    logic          locked;
    logic          err_illegal;
    logic          err_seq;
    logic          wrap;
    logic [7:0]    err_cnt;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    // Reference model: last legal phase, length of the current correct-step run
    // (-1 when no legal sample since reset/illegal), error count.
    int   m_idx;
    bit   m_vld;
    int   m_run;
    int   m_cnt;
    int   cur;

    johnson_phase_tracker #(.M(M), .LOCK_CNT(L)) dut (
        .clk(clk), .rst_n(rst_n), .jc_in(jc_in), .en(en), .clear_err(clear_err),
        .phase_idx(phase_idx), .phase_onehot(phase_onehot), .phase_vld(phase_vld),
        .locked(locked), .err_illegal(err_illegal), .err_seq(err_seq),
        .wrap(wrap), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [M-1:0] jc_of(input int p);
        if (p <= M) return M'((1 << p) - 1);
        return M'(((1 << M) - 1) - ((1 << (p - M)) - 1));
    endfunction

    // Legal iff the code is a contiguous block of ones anchored at the LSB
    // (rising half) or at the MSB (falling half); phase follows from the count.
    function automatic bit decode(input logic [M-1:0] c, output int p);
        int k;
        k = $countones(c);
        p = 0;
        if (int'(c) == (1 << k) - 1) begin
            p = k;
            return 1'b1;
        end
        if (k > 0 && int'(c) == ((1 << M) - 1) - ((1 << (M - k)) - 1)) begin
            p = 2 * M - k;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_vld = 1'b0;
        m_run = -1;
        m_cnt = 0;
    endtask

    task automatic model_apply(input logic e, input logic [M-1:0] c,
                               input logic clr, output exp_t x);
        int  p;
        bit  legal;
        bit  was_locked;
        bit  nxt;
        bit  inc;
        x          = '0;
        inc        = 1'b0;
        was_locked = (m_run >= int'(L));
        legal      = decode(c, p);
        if (e) begin
            if (!legal) begin
                m_run  = -1;
                m_vld  = 1'b0;
                x.eill = 1'b1;
                inc    = 1'b1;
            end else begin
                nxt = (m_run >= 0) && (p == (m_idx + 1) % int'(NP));
                if (nxt) begin
                    x.wrp = was_locked && (m_idx == int'(NP) - 1);
                    m_run = (m_run + 1 > int'(L)) ? int'(L) : m_run + 1;
                end else begin
                    if (was_locked) begin
                        x.eseq = 1'b1;
                        inc    = 1'b1;
                    end
                    m_run = 0;
                end
                m_idx = p;
                m_vld = 1'b1;
            end
        end
        if (clr) m_cnt = 0;
        else if (inc && m_cnt < 255) m_cnt++;
        x.idx = PW'(m_idx);
        x.vld = m_vld;
        x.oh  = m_vld ? (NP'(1) << m_idx) : '0;
        x.lk  = (m_run >= int'(L));
        x.cnt = 8'(m_cnt);
    endtask

    task automatic step(input logic e, input logic [M-1:0] c, input logic clr);
        exp_t x;
        @(negedge clk);
        en        = e;
        jc_in     = c;
        clear_err = clr;
        model_apply(e, c, clr, x);
        sb.push_back(x);
    endtask

    task automatic walk(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            cur = (from + i) % int'(NP);
            step(1'b1, jc_of(cur), 1'b0);
        end
    endtask

    // Monitor: every post-edge sample with an outstanding expectation is compared.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("phase_idx",    int'(phase_idx),    int'(x.idx));
                chk("phase_onehot", int'(phase_onehot), int'(x.oh));
                chk("phase_vld",    int'(phase_vld),    int'(x.vld));
                chk("locked",       int'(locked),       int'(x.lk));
                chk("err_illegal",  int'(err_illegal),  int'(x.eill));
                chk("err_seq",      int'(err_seq),      int'(x.eseq));
                chk("wrap",         int'(wrap),         int'(x.wrp));
                chk("err_cnt",      int'(err_cnt),      int'(x.cnt));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_idx"},    int'(phase_idx),    0);
        chk({tag, "_onehot"}, int'(phase_onehot), 0);
        chk({tag, "_vld"},    int'(phase_vld),    0);
        chk({tag, "_locked"}, int'(locked),       0);
        chk({tag, "_pulses"}, int'({err_illegal, err_seq, wrap}), 0);
        chk({tag, "_cnt"},    int'(err_cnt),      0);
    endtask

    initial begin
        int r;
        logic [M-1:0] c;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        jc_in     = '0;
        clear_err = 1'b0;
        cur       = 0;
        model_reset();
        #3;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Acquire from phase 0, lock on the 4th sample, walk through a wrap.
        walk(0, 4);
        walk(4, 5);

        // Illegal code while locked, then relock with four correct codes.
        step(1'b1, 4'b0101, 1'b0);
        walk(1, 4);

        // Lock ending at phase 2, then jump to phase 4.
        walk(7, 4);
        step(1'b1, jc_of(4), 1'b0);
        cur = 4;
        walk(5, 4);

        // Qualifier low with a changing input, then resume with the next phase.
        for (int i = 0; i < 3; i++) step(1'b0, M'($urandom), 1'b0);
        walk(cur + 1, 3);

        // Repeated code counts as a break.
        step(1'b1, jc_of(cur), 1'b0);
        walk(cur + 1, 4);

        // Saturate the error count, then clear coincident with an illegal code.
        for (int i = 0; i < 300; i++) step(1'b1, 4'b0101, 1'b0);
        step(1'b1, 4'b1010, 1'b1);
        step(1'b1, 4'b0110, 1'b0);
        step(1'b0, 4'b1011, 1'b1);

        // Asynchronous reset mid-operation while locked.
        walk(2, 5);
        @(posedge clk);
        #3;
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        walk(cur + 1, 5);

        // Randomized walk dominated by correct steps.
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                cur = (cur + 1) % int'(NP);
                step(1'b1, jc_of(cur), ($urandom_range(0, 49) == 0));
            end else if (r < 80) begin
                cur = int'($urandom_range(0, NP - 1));
                step(1'b1, jc_of(cur), 1'b0);
            end else if (r < 88) begin
                c = M'($urandom);
                step(1'b1, c, 1'b0);
            end else if (r < 96) begin
                step(1'b0, M'($urandom), ($urandom_range(0, 9) == 0));
            end else begin
                step(1'b1, jc_of(cur), 1'b1);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
